time_keeper: RTL and testbench
==============================

Name: time_keeper

Overview:
- Real-time BCD clock counter that produces `current_time` for the mode/alarm stage, directly upstream of it.
- Derives a 1 Hz tick from the system clock and advances HH:MM:SS in 24 h format.
- Applies single-cycle hour/minute edit pulses, taken from the mode stage's clock-edit outputs, to the running time.
- Exports a seconds-tick strobe for display blink and alarm-ringer logic.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz; the prescaler terminal count is CLK_FREQ-1. Benches use a small value, e.g. 4.

Ports:
- clk  input  1  system clock. The block uses this single clock only.
- reset  input  1  asynchronous, active-low reset (asserted at 0).
- edit_btns  input  2  single-cycle edit pulses: [1] increments hours, [0] increments minutes.
- run  input  1  1 = time advances on ticks; 0 = time frozen and prescaler held at 0. Edits still apply when run=0.
- current_time  output  20  BCD time:
  - [19:18] hour tens (0-2)
  - [17:14] hour units
  - [13:11] minute tens (0-5)
  - [10:7] minute units
  - [6:4] second tens (0-5)
  - [3:0] second units
- sec_tick  output  1  one-cycle pulse, registered, asserted on the cycle the seconds field updates from a tick.

Behaviour:
- Reset (reset=0, async): prescaler=0, current_time=20'h00000 (00:00:00), sec_tick=0. Release is synchronous to clk; the first tick comes CLK_FREQ cycles after release when run=1.
- Prescaler: counts 0..CLK_FREQ-1 while run=1.
  - Internal tick is asserted in the cycle the count equals CLK_FREQ-1; the count then wraps to 0.
  - When run=0, the count is held at 0 and no tick is generated.
- Tick update (registered, visible the cycle after the tick):
  - Seconds units 9->0 carries into seconds tens; seconds 59->00 carries into minutes.
  - Minutes units 9->0 carries into minute tens; minutes 59->00 carries into hours.
  - Hours: units 9->0 carries into tens; 23->00 wraps with no further carry.
  - sec_tick=1 in the same cycle the new value appears.
- Each BCD digit stays within its legal range at all times. Values like 24:xx or x:6x are never produced.
- Hour edit (edit_btns[1]=1): hours +1 on the next cycle, 23->00. Minutes and seconds are unaffected.
- Minute edit (edit_btns[0]=1):
  - Minutes +1 on the next cycle, 59->00, with no carry into hours.
  - Seconds cleared to 00, prescaler cleared to 0, sec_tick suppressed (0) that cycle.
- Both edit bits in the same cycle: both apply; hours +1, minutes +1, seconds cleared.
- Tick coincident with minute edit: the minute edit wins. The tick is discarded entirely (no seconds advance, no carry, sec_tick=0).
- Tick coincident with hour edit only:
  - Seconds and minutes update per the tick; sec_tick=1.
  - Hours = old hours +1 (edit); any tick carry into hours in that cycle is dropped.
- Edit latency is exactly 1 cycle. Edit pulses are assumed ≤1 cycle wide; a held level increments once per cycle.
- Reset asserted mid-count or mid-edit returns all state to reset values immediately, independent of clk.
- current_time and sec_tick are driven directly from flops; there is no combinational path from inputs to outputs.

Test Plan:
- CLK_FREQ=4, release reset, run=1 -> current_time 00:00:00 (20'h00000) for 4 cycles, then 00:00:01 with sec_tick=1 for exactly one cycle; sec_tick=1 every 4th cycle thereafter.
- Preload 23:59:59 via edits/ticks, one tick -> 00:00:00, sec_tick=1. From 09:59:59, one tick -> 10:00:00 (BCD digit rollover).
- Hour edit pulse at 23:15:30 -> 00:15:30 one cycle later. Minute edit at 12:59:42 -> 12:00:00, prescaler restarts so the next tick comes 4 cycles later.
- Minute edit coincident with a tick at 05:10:20 -> 05:11:00, sec_tick=0. Hour edit coincident with tick at 05:59:59 -> 06:00:00 (edit only, carry dropped), sec_tick=1.
- run=0 for 20 cycles -> time frozen, sec_tick never asserts. Edits still increment. run=1 -> first tick 4 cycles later.
- Assert reset=0 asynchronously between clock edges at 14:33:07 -> outputs 20'h00000 and sec_tick=0 before the next clk edge; they remain so until release.

Source files
------------

// File: rtl/time_keeper.sv
// time_keeper: 24 h BCD real-time clock with a prescaled 1 Hz tick,
// single-cycle hour/minute edit pulses and a registered seconds strobe.
module time_keeper #(
   parameter int CLK_FREQ = 100_000_000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  edit_btns,
   input  logic        run,
   output logic [19:0] current_time,
   output logic        sec_tick
);
   localparam int CW = CLK_FREQ > 1 ? $clog2(CLK_FREQ) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLK_FREQ - 1);
   logic [CW-1:0] cnt, cnt_n;
   logic [1:0] ht, ht_i, ht_n;
   logic [3:0] hu, hu_i, hu_n;
   logic [2:0] mt, mt_i, mt_n;
   logic [3:0] mu, mu_i, mu_n;
   logic [2:0] st, st_i, st_n;
   logic [3:0] su, su_i, su_n;
   logic tick, hr_ed, mn_ed, adv, sec_wrap, min_wrap, hr_wrap;
   assign tick     = run && cnt == LAST;
   assign hr_ed    = edit_btns[1];
   assign mn_ed    = edit_btns[0];
   assign adv      = tick && !mn_ed;
   assign sec_wrap = st == 3'd5 && su == 4'd9;
   assign min_wrap = mt == 3'd5 && mu == 4'd9;
   assign hr_wrap  = ht == 2'd2 && hu == 4'd3;
   // Wrapped +1 of each digit pair, independent of why it is advanced
   assign su_i = su == 4'd9 ? 4'd0 : su + 4'd1;
   assign st_i = su == 4'd9 ? (st == 3'd5 ? 3'd0 : st + 3'd1) : st;
   assign mu_i = mu == 4'd9 ? 4'd0 : mu + 4'd1;
   assign mt_i = mu == 4'd9 ? (mt == 3'd5 ? 3'd0 : mt + 3'd1) : mt;
   assign hu_i = hr_wrap ? 4'd0 : hu == 4'd9 ? 4'd0 : hu + 4'd1;
   assign ht_i = hr_wrap ? 2'd0 : hu == 4'd9 ? ht + 2'd1 : ht;
   // A minute edit discards a coincident tick; an hour edit drops its carry
   always_comb begin
      cnt_n = (!run || mn_ed || tick) ? '0 : cnt + CW'(1);
      su_n  = mn_ed ? 4'd0 : adv ? su_i : su;
      st_n  = mn_ed ? 3'd0 : adv ? st_i : st;
      mu_n  = (mn_ed || (adv && sec_wrap)) ? mu_i : mu;
      mt_n  = (mn_ed || (adv && sec_wrap)) ? mt_i : mt;
      hu_n  = (hr_ed || (adv && sec_wrap && min_wrap)) ? hu_i : hu;
      ht_n  = (hr_ed || (adv && sec_wrap && min_wrap)) ? ht_i : ht;
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt      <= '0;
         {ht, hu, mt, mu, st, su} <= '0;
         sec_tick <= 1'b0;
      end else begin
         cnt      <= cnt_n;
         {ht, hu, mt, mu, st, su} <= {ht_n, hu_n, mt_n, mu_n, st_n, su_n};
         sec_tick <= adv;
      end
   end
   assign current_time = {ht, hu, mt, mu, st, su};
endmodule

// File: tb/tb_time_keeper.sv
// tb_time_keeper: vector table, directed corner sequences and a randomized
// run against an arithmetic hh:mm:ss reference model.
module tb_time_keeper;
   localparam int F = 4;
   logic clk = 1'b0, reset = 1'b0, run = 1'b0, sec_tick;
   logic [1:0] edit_btns = 2'b00;
   logic [19:0] current_time;
   int total = 0, bad = 0;
   int mh, mm, ms, mpc;
   logic mst;

   time_keeper #(.CLK_FREQ(F)) dut (
      .clk(clk), .reset(reset), .edit_btns(edit_btns), .run(run),
      .current_time(current_time), .sec_tick(sec_tick)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  e;
      logic        r;
      logic [19:0] t;
      logic        s;
   } vec_t;
   vec_t vecs[16];

   function automatic logic [19:0] bcd(input int h, input int m, input int s);
      return {2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10), 3'(s / 10), 4'(s % 10)};
   endfunction

   task automatic chk(input string nm, input logic [19:0] et, input logic es);
      total++;
      if (current_time !== et || sec_tick !== es) begin
         bad++;
         $display("FAIL %s: got time=%05h tick=%b, want time=%05h tick=%b",
                  nm, current_time, sec_tick, et, es);
      end
   endtask

   // Reference: whole-day seconds arithmetic plus an integer prescaler
   task automatic model_step(input logic [1:0] e, input logic r);
      bit tk;
      int t, nh;
      tk = r && mpc == F - 1;
      t  = (mh * 3600 + mm * 60 + ms + 1) % 86400;
      nh = t / 3600;
      if (e[0]) begin
         mm = (mm + 1) % 60;
         ms = 0;
      end else if (tk) begin
         ms = t % 60;
         mm = (t / 60) % 60;
      end
      if (e[1]) mh = (mh + 1) % 24;
      else if (tk && !e[0]) mh = nh;
      mpc = (!r || e[0] || tk) ? 0 : mpc + 1;
      mst = tk && !e[0];
   endtask

   task automatic cyc(input logic [1:0] e, input logic r);
      edit_btns = e;
      run = r;
      @(posedge clk);
      #1;
      model_step(e, r);
   endtask

   task automatic rst(input logic r);
      #2 reset = 1'b0;
      run = r;
      edit_btns = 2'b00;
      #1 chk("reset", 20'h00000, 1'b0);
      mh = 0; mm = 0; ms = 0; mpc = 0; mst = 1'b0;
      @(posedge clk);
      #1 reset = 1'b1;
   endtask

   task automatic set_time(input int h, input int m, input int s);
      rst(1'b0);
      for (int i = 0; i < m; i++) cyc(2'b01, 1'b0);
      for (int i = 0; i < h; i++) cyc(2'b10, 1'b0);
      for (int i = 0; i < F * s; i++) cyc(2'b00, 1'b1);
      chk("preload", bcd(h, m, s), s > 0);
   endtask

   initial begin
      vecs[0]  = '{2'b00, 1'b1, 20'h00000, 1'b0};
      vecs[1]  = '{2'b00, 1'b1, 20'h00000, 1'b0};
      vecs[2]  = '{2'b00, 1'b1, 20'h00000, 1'b0};
      vecs[3]  = '{2'b00, 1'b1, 20'h00001, 1'b1};
      vecs[4]  = '{2'b00, 1'b1, 20'h00001, 1'b0};
      vecs[5]  = '{2'b00, 1'b1, 20'h00001, 1'b0};
      vecs[6]  = '{2'b00, 1'b1, 20'h00001, 1'b0};
      vecs[7]  = '{2'b00, 1'b1, 20'h00002, 1'b1};
      vecs[8]  = '{2'b01, 1'b1, 20'h00080, 1'b0};
      vecs[9]  = '{2'b10, 1'b0, 20'h04080, 1'b0};
      vecs[10] = '{2'b00, 1'b0, 20'h04080, 1'b0};
      vecs[11] = '{2'b00, 1'b1, 20'h04080, 1'b0};
      vecs[12] = '{2'b00, 1'b1, 20'h04080, 1'b0};
      vecs[13] = '{2'b00, 1'b1, 20'h04080, 1'b0};
      vecs[14] = '{2'b00, 1'b1, 20'h04081, 1'b1};
      vecs[15] = '{2'b01, 1'b1, 20'h04100, 1'b0};
      @(posedge clk);
      #1;
      rst(1'b1);
      for (int i = 0; i < 16; i++) begin
         cyc(vecs[i].e, vecs[i].r);
         chk($sformatf("vec%0d", i), vecs[i].t, vecs[i].s);
      end
      // day rollover and BCD hour-digit rollover
      set_time(23, 59, 59);
      for (int i = 0; i < F - 1; i++) cyc(2'b00, 1'b1);
      cyc(2'b00, 1'b1);
      chk("day_wrap", 20'h00000, 1'b1);
      set_time(9, 59, 59);
      for (int i = 0; i < F; i++) cyc(2'b00, 1'b1);
      chk("hour_digit", 20'h40000, 1'b1);
      // hour edit wraps 23 -> 00
      set_time(23, 15, 30);
      cyc(2'b10, 1'b0);
      chk("hour_edit_wrap", 20'h00AB0, 1'b0);
      // minute edit mid-count restarts the prescaler
      set_time(12, 59, 42);
      cyc(2'b00, 1'b1);
      cyc(2'b00, 1'b1);
      cyc(2'b01, 1'b1);
      chk("min_edit", 20'h48000, 1'b0);
      for (int i = 0; i < F - 1; i++) begin
         cyc(2'b00, 1'b1);
         chk("min_edit_hold", 20'h48000, 1'b0);
      end
      cyc(2'b00, 1'b1);
      chk("min_edit_tick", 20'h48001, 1'b1);
      // minute edit beats a coincident tick
      set_time(5, 10, 20);
      for (int i = 0; i < F - 1; i++) cyc(2'b00, 1'b1);
      cyc(2'b01, 1'b1);
      chk("min_edit_vs_tick", 20'h14880, 1'b0);
      // hour edit with tick: carry into hours dropped
      set_time(5, 59, 59);
      for (int i = 0; i < F - 1; i++) cyc(2'b00, 1'b1);
      cyc(2'b10, 1'b1);
      chk("hour_edit_vs_tick", 20'h18000, 1'b1);
      // frozen while run=0, edits still apply
      for (int i = 0; i < 20; i++) begin
         cyc(2'b00, 1'b0);
         chk("frozen", 20'h18000, 1'b0);
      end
      cyc(2'b10, 1'b0);
      chk("frozen_edit", 20'h1C000, 1'b0);
      for (int i = 0; i < F - 1; i++) begin
         cyc(2'b00, 1'b1);
         chk("resume_hold", 20'h1C000, 1'b0);
      end
      cyc(2'b00, 1'b1);
      chk("resume_tick", 20'h1C001, 1'b1);
      // asynchronous reset between edges
      set_time(14, 33, 7);
      #2 reset = 1'b0;
      #1 chk("async_reset", 20'h00000, 1'b0);
      @(posedge clk);
      #1 chk("reset_held", 20'h00000, 1'b0);
      reset = 1'b1;
      // randomized run against the reference model
      rst(1'b1);
      for (int i = 0; i < 4000; i++) begin
         cyc({2'($urandom_range(0, 15) == 0) != 2'd0, 2'($urandom_range(0, 11) == 0) != 2'd0},
             $urandom_range(0, 9) != 0);
         chk("random", bcd(mh, mm, ms), mst);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
